onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Two-master burst arbiter in front of the single-port on-chip RAM (32768 × 32-bit words, byte enables, one-cycle read latency). It shares the RAM's one port between two Avalon-MM style masters with round-robin fairness. It expands each master's incrementing burst into consecutive single-word RAM accesses and routes read data back to the issuing master. It sits between the interconnect-side masters and the RAM's address/byteenable/chipselect/write/writedata/readdata/clken port.

## Interface
- ADDR_W, 15, word-address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- MAX_BURST, 8, longest burst in beats
- BC_W, 4, burstcount width (enough to encode MAX_BURST)

Ports:
- clk  in  1  single clock for the block and the RAM
- reset  in  1  asynchronous, active-high
- mN_address  in  ADDR_W  start word address (N = 0, 1; all mN_ ports exist for both masters)
- mN_read / mN_write  in  1  request strobes, mutually exclusive per master
- mN_writedata  in  DATA_W  write beat data
- mN_byteenable  in  BE_W  per-beat byte lanes; reads ignore it and return all lanes
- mN_burstcount  in  BC_W  beats; 0 is treated as 1, values above MAX_BURST as MAX_BURST
- mN_waitrequest  out  1  command/beat not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata valid for master N
- mem_address  out  ADDR_W, mem_byteenable  out  BE_W, mem_writedata  out  DATA_W  RAM port
- mem_chipselect / mem_write  out  1  RAM access / write strobe
- mem_clken  out  1  RAM clock enable, constant 1
- mem_readdata  in  DATA_W  RAM q, valid one cycle after address

## Operation
- States: ARB_IDLE, ARB_RD_BURST, ARB_WR_BURST.
- ARB_IDLE: the picker chooses among masters with read|write asserted.
  - Winner gets waitrequest=0. Its first beat drives the RAM combinationally in the same cycle.
  - Loser sees waitrequest=1.
  - Effective burstcount of 1 → stay in ARB_IDLE.
  - Otherwise latch the owner, set beats_left = count−1 and addr = address+1, then go to RD_BURST or WR_BURST.
- ARB_RD_BURST: issue one read per cycle from the internal addr, with both waitrequest=1. Go back to ARB_IDLE after the beat with beats_left=1.
- ARB_WR_BURST:
  - Owner waitrequest=0; other master waitrequest=1.
  - A beat is issued only in cycles where the owner asserts write. mem_writedata and mem_byteenable come from the owner.
  - If the owner deasserts write, the block stalls with mem_chipselect=0 and keeps the grant.
  - Go back to ARB_IDLE after the last beat.
- Address arithmetic is modulo 2^ADDR_W, so 32767 wraps to 0 inside a burst.
- Round-robin rule:
  - rr holds the last granted master and updates on every grant in ARB_IDLE.
  - When both masters request, the grant goes to the master that is not rr.
  - A single requester always wins.
- Read return: every issued read beat pushes (valid, owner) into a return pipe.
  - At the pipe output, mem_readdata goes to both mN_readdata.
  - Only the owner's readdatavalid pulses.
- Requests arriving during a burst wait, and their waitrequest stays high until the next ARB_IDLE grant.
- Reset (any cycle, including mid-burst): state=ARB_IDLE, rr=1 (so m0 wins the first tie), beats_left=0, return pipe cleared. The partial burst is abandoned and no readdatavalid is produced for it.
- Outputs during reset: both readdatavalid=0, mem_chipselect=0, mem_write=0, both waitrequest=1, mem_clken=1.

## Timing
- Grant latency: 0 cycles when in ARB_IDLE.
- Read data: readdatavalid 1 cycle after the beat's mem_chipselect cycle (2 cycles with ONCHIP_ARB_RDREG_EN).
- N-beat read burst: occupies the RAM for exactly N consecutive cycles.
- N-beat write burst: occupies at least N cycles, plus one cycle per owner stall.
- No bubble between bursts: the cycle after a last beat is ARB_IDLE and can grant.
- Read data from a previous burst can return in the same cycle as a new grant.

## Configuration
- ONCHIP_ARB_RDREG_EN defined: mem_readdata is registered before fan-out, and the return pipe is 2 deep. This closes timing on the RAM's unregistered output.
- Not defined: the return pipe is 1 deep and readdata is a direct wire from mem_readdata.

## Structure
- Package onchip_arb_pkg holds:
  - ADDR_W/DATA_W/BE_W/MAX_BURST defaults
  - typedef arb_state_t {ARB_IDLE, ARB_RD_BURST, ARB_WR_BURST}
  - typedef arb_id_t (1-bit master id)
  - the read-return pipe entry struct {valid, id}
- Sub-module onchip_arb_rr: 2-way round-robin picker (requests, rr in → grant one-hot, winner id out).

## Test plan
- m0 single read at 0x0010 with RAM word 0xDEADBEEF → m0_waitrequest=0 in the same cycle; m0_readdatavalid pulses 1 cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both issue single writes every cycle from reset → grants alternate m0, m1, m0, ...; the loser's waitrequest=1 in each cycle.
- m1 read burst of 4 from 0x7FFE → mem_address 0x7FFE, 0x7FFF, 0x0000, 0x0001 on consecutive cycles; 4 consecutive m1_readdatavalid pulses.
- m0 write burst of 3 with write dropped for 2 cycles after beat 1 → mem_chipselect low for exactly those 2 cycles; m1 request held off until after beat 3.
- Reset asserted on the 2nd beat of a 4-beat read → next cycle: ARB_IDLE, no further readdatavalid, mem_chipselect=0.
- burstcount=0 and burstcount=15 → treated as 1 and 8 beats respectively.

Source files
------------

// File: rtl/onchip_arb_pkg.sv
// Shared types and default geometry for the on-chip RAM burst arbiter.
package onchip_arb_pkg;

    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BE_W      = DEF_DATA_W / 8;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_BC_W      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD_BURST,
        ARB_WR_BURST
    } arb_state_t;

    typedef logic arb_id_t;

    // One slot of the read-return pipe: which master a returning read word belongs to.
    typedef struct packed {
        logic    valid;
        arb_id_t id;
    } rd_ret_t;

endpackage

// File: rtl/onchip_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master that did not win last.
module onchip_arb_rr
    import onchip_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_id_t    rr_i,
    output logic [1:0] gnt_o,
    output arb_id_t    win_o
);

    always_comb begin
        win_o = req_i[0] ? 1'b0 : 1'b1;
        if (&req_i) begin
            win_o = ~rr_i;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o[win_o] = 1'b1;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port RAM between two Avalon-MM style masters.
// Define ONCHIP_ARB_RDREG_EN to register mem_readdata before fan-out (two-deep return pipe).
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DEF_BE_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int BC_W      = DEF_BC_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [BC_W-1:0]   m0_burstcount,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [BC_W-1:0]   m1_burstcount,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    function automatic logic [BC_W-1:0] eff_count(input logic [BC_W-1:0] bc);
        if (bc == '0)               return BC_W'(1);
        if (bc > BC_W'(MAX_BURST))  return BC_W'(MAX_BURST);
        return bc;
    endfunction

    logic [1:0]             req, gnt, m_wr, wait_req;
    logic [1:0][ADDR_W-1:0] m_addr;
    logic [1:0][DATA_W-1:0] m_wdata;
    logic [1:0][BE_W-1:0]   m_be;
    logic [1:0][BC_W-1:0]   m_bc;
    arb_id_t                win, sel;
    logic [BC_W-1:0]        cnt;
    logic                   mem_cs, mem_we, rd_issue;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      rdata;

    arb_state_t        state_q, state_d;
    arb_id_t           owner_q, owner_d, rr_q, rr_d;
    logic [BC_W-1:0]   beats_left_q, beats_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign m_wr    = {m1_write, m0_write};
    assign m_addr  = {m1_address, m0_address};
    assign m_wdata = {m1_writedata, m0_writedata};
    assign m_be    = {m1_byteenable, m0_byteenable};
    assign m_bc    = {m1_burstcount, m0_burstcount};

    onchip_arb_rr u_rr (
        .req_i (req),
        .rr_i  (rr_q),
        .gnt_o (gnt),
        .win_o (win)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        wait_req     = 2'b11;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_q;
        sel          = owner_q;
        cnt          = eff_count(m_bc[win]);
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        beats_left_d = beats_left_q;
        addr_d       = addr_q;
        case (state_q)
            ARB_IDLE: begin
                sel = win;
                if (|req) begin
                    wait_req = ~gnt;
                    mem_cs   = 1'b1;
                    mem_we   = m_wr[win];
                    mem_addr = m_addr[win];
                    rr_d     = win;
                    if (cnt != BC_W'(1)) begin
                        owner_d      = win;
                        beats_left_d = cnt - BC_W'(1);
                        addr_d       = m_addr[win] + ADDR_W'(1);
                        state_d      = m_wr[win] ? ARB_WR_BURST : ARB_RD_BURST;
                    end
                end
            end
            ARB_RD_BURST: begin
                mem_cs       = 1'b1;
                beats_left_d = beats_left_q - BC_W'(1);
                addr_d       = addr_q + ADDR_W'(1);
                if (beats_left_q == BC_W'(1)) state_d = ARB_IDLE;
            end
            ARB_WR_BURST: begin
                // The owner keeps its grant across write stalls; a beat goes out only when it drives write.
                wait_req[owner_q] = 1'b0;
                if (m_wr[owner_q]) begin
                    mem_cs       = 1'b1;
                    mem_we       = 1'b1;
                    beats_left_d = beats_left_q - BC_W'(1);
                    addr_d       = addr_q + ADDR_W'(1);
                    if (beats_left_q == BC_W'(1)) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // NOTE: reset is asynchronous, so the combinational grant path is gated too; state alone would lag.
        if (reset) begin
            wait_req = 2'b11;
            mem_cs   = 1'b0;
            mem_we   = 1'b0;
        end
    end

    assign rd_issue = mem_cs & ~mem_we;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b1;
            beats_left_q <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            beats_left_q <= beats_left_d;
            addr_q       <= addr_d;
        end
    end

`ifdef ONCHIP_ARB_RDREG_EN
    localparam int RET_DEPTH = 2;
    logic [DATA_W-1:0] rdata_q;
    // NOTE: pure datapath register, qualified by the return pipe's valid, so it carries no reset.
    always_ff @(posedge clk) begin
        rdata_q <= mem_readdata;
    end
    assign rdata = rdata_q;
`else
    localparam int RET_DEPTH = 1;
    assign rdata = mem_readdata;
`endif

    rd_ret_t ret_q [RET_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RET_DEPTH; i++) ret_q[i] <= '0;
        end else begin
            ret_q[0] <= '{valid: rd_issue, id: sel};
            for (int i = 1; i < RET_DEPTH; i++) ret_q[i] <= ret_q[i-1];
        end
    end

    assign m0_readdatavalid = ret_q[RET_DEPTH-1].valid && (ret_q[RET_DEPTH-1].id == 1'b0);
    assign m1_readdatavalid = ret_q[RET_DEPTH-1].valid && (ret_q[RET_DEPTH-1].id == 1'b1);
    assign m0_readdata      = rdata;
    assign m1_readdata      = rdata;
    assign m0_waitrequest   = wait_req[0];
    assign m1_waitrequest   = wait_req[1];
    assign mem_address      = mem_addr;
    assign mem_chipselect   = mem_cs;
    assign mem_write        = mem_we;
    assign mem_writedata    = m_wdata[sel];
    assign mem_byteenable   = m_be[sel];
    assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus random two-master traffic vs a transaction-level model.
module tb_onchip_mem_arbiter;

    localparam int AW = 15;
`ifdef ONCHIP_ARB_RDREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    rd = '0, wr = '0;
    logic [AW-1:0] ad [2];
    logic [31:0]   wd [2];
    logic [3:0]    be [2];
    logic [3:0]    bc [2];
    logic [1:0]    wt, rdv;
    logic [31:0]   rdat [2];

    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [31:0]   mem_readdata = '0;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (ad[0]),
        .m0_read          (rd[0]),
        .m0_write         (wr[0]),
        .m0_writedata     (wd[0]),
        .m0_byteenable    (be[0]),
        .m0_burstcount    (bc[0]),
        .m0_waitrequest   (wt[0]),
        .m0_readdata      (rdat[0]),
        .m0_readdatavalid (rdv[0]),
        .m1_address       (ad[1]),
        .m1_read          (rd[1]),
        .m1_write         (wr[1]),
        .m1_writedata     (wd[1]),
        .m1_byteenable    (be[1]),
        .m1_burstcount    (bc[1]),
        .m1_waitrequest   (wt[1]),
        .m1_readdata      (rdat[1]),
        .m1_readdatavalid (rdv[1]),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        return ({17'h0, a} * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic int eff(input logic [3:0] b);
        if (b == 4'd0) return 1;
        if (b > 4'd8) return 8;
        return int'(b);
    endfunction

    // RAM behind the arbiter: one-cycle read latency, byte-enabled writes.
    logic [31:0] ram [32768];
    logic        ram_clr = 1'b1;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32768; i++) ram[i] <= init_val(AW'(i));
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            else           mem_readdata <= ram[mem_address];
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int m = 0; m < 2; m++) begin
            ad[m] = '0; wd[m] = '0; be[m] = 4'hF; bc[m] = 4'd1;
        end
        rd = '0; wr = '0;
    endtask

    task automatic do_reset(input bit clr);
        idle_all();
        reset = 1'b1;
        ram_clr = clr;
        rd = 2'b11;
        sample();
        check("rst_wait", wt, 2'b11);
        check("rst_cs_we", {mem_chipselect, mem_write}, 2'b00);
        check("rst_clken", mem_clken, 1'b1);
        check("rst_rdv", rdv, 2'b00);
        drive_edge();
        ram_clr = 1'b0;
        rd = 2'b00;
        drive_edge();
        reset = 1'b0;
    endtask

    task automatic run_read(input int m, input logic [AW-1:0] a, input logic [3:0] b, input int exp_n);
        int  n_cs, n_rdv;
        bit  to;
        n_cs = 0; n_rdv = 0; to = 1'b1;
        rd[m] = 1'b1; ad[m] = a; bc[m] = b;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (!wt[m]) begin to = 1'b0; break; end
            drive_edge();
        end
        check("grant_timeout", to, 1'b0);
        if (mem_chipselect) n_cs++;
        drive_edge();
        rd[m] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (mem_chipselect) n_cs++;
            if (rdv[m]) n_rdv++;
            drive_edge();
        end
        check("clamp_beats", n_cs, exp_n);
        check("clamp_rdv", n_rdv, exp_n);
    endtask

    // Transaction-level model state for the random phase.
    typedef struct packed {
        logic [AW-1:0] a;
        logic          w;
        logic [31:0]   d;
        logic [3:0]    b;
    } acc_t;

    logic [31:0] ref_mem [32768];
    logic [31:0] exp_rd [2][$];
    acc_t        acc_q [$];
    bit          act [2];
    bit          is_wr [2];
    logic [AW-1:0] st [2];
    int          nb [2];
    int          idx [2];
    int          last_win;
    bit          stop;

    task automatic monitor();
        logic [1:0] acc;
        acc_t       got, exp;
        for (int m = 0; m < 2; m++) acc[m] = (rd[m] | wr[m]) & ~wt[m];
        if (&acc) check("dual_accept", acc, 2'b00);
        for (int m = 0; m < 2; m++) begin
            if (acc[m]) begin
                if (idx[m] == 0) begin
                    if (rd[1-m] | wr[1-m]) check("rr_pick", m, 1 - last_win);
                    last_win = m;
                end
                if (!is_wr[m]) begin
                    for (int k = 0; k < nb[m]; k++) begin
                        logic [AW-1:0] a;
                        a = st[m] + AW'(k);
                        exp_rd[m].push_back(ref_mem[a]);
                        acc_q.push_back('{a: a, w: 1'b0, d: 32'h0, b: 4'h0});
                    end
                    act[m] = 1'b0;
                end else begin
                    logic [AW-1:0] a;
                    a = st[m] + AW'(idx[m]);
                    acc_q.push_back('{a: a, w: 1'b1, d: wd[m], b: be[m]});
                    ref_mem[a] = merge(ref_mem[a], wd[m], be[m]);
                    idx[m]++;
                    if (idx[m] == nb[m]) act[m] = 1'b0;
                end
            end
        end
        if (mem_chipselect) begin
            got = '{a: mem_address, w: mem_write,
                    d: mem_write ? mem_writedata : 32'h0, b: mem_write ? mem_byteenable : 4'h0};
            if (acc_q.size() == 0) begin
                check("ram_access_unexpected", got, 52'h0);
            end else begin
                exp = acc_q.pop_front();
                check("ram_access", got, exp);
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (rdv[m]) begin
                if (exp_rd[m].size() == 0) check("rdv_unexpected", rdv[m], 1'b0);
                else                       check("rd_data", rdat[m], exp_rd[m].pop_front());
            end
        end
    endtask

    task automatic drive_rand();
        for (int m = 0; m < 2; m++) begin
            if (act[m]) begin
                if (is_wr[m]) begin
                    wd[m] = $urandom;
                    be[m] = 4'($urandom);
                    wr[m] = (idx[m] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
            end else if (!stop && $urandom_range(0, 2) == 0) begin
                is_wr[m] = 1'($urandom);
                if ($urandom_range(0, 3) == 0) st[m] = 15'h7FFA + AW'($urandom_range(0, 5));
                else                           st[m] = AW'($urandom);
                bc[m]  = 4'($urandom);
                nb[m]  = eff(bc[m]);
                idx[m] = 0;
                act[m] = 1'b1;
                ad[m]  = st[m];
                rd[m]  = ~is_wr[m];
                wr[m]  = is_wr[m];
                wd[m]  = $urandom;
                be[m]  = 4'($urandom);
            end else begin
                rd[m] = 1'b0;
                wr[m] = 1'b0;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        do_reset(1'b1);

        // Single write then single read at 0x0010.
        wr[0] = 1'b1; ad[0] = 15'h0010; wd[0] = 32'hDEADBEEF; be[0] = 4'hF; bc[0] = 4'd1;
        sample();
        check("t1_wr_wait", wt[0], 1'b0);
        drive_edge();
        wr[0] = 1'b0; rd[0] = 1'b1;
        sample();
        check("t1_rd_wait", wt[0], 1'b0);
        check("t1_rd_bus", {mem_chipselect, mem_write, mem_address}, {2'b10, 15'h0010});
        drive_edge();
        rd[0] = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            sample();
            check("t1_rdv_early", rdv, 2'b00);
            drive_edge();
        end
        sample();
        check("t1_rdv", rdv, 2'b01);
        check("t1_rdata", rdat[0], 32'hDEADBEEF);
        drive_edge();

        // Both masters issue single writes every cycle from reset: grants alternate from m0.
        do_reset(1'b0);
        wr = 2'b11; ad[0] = 15'h0100; ad[1] = 15'h0200;
        for (int i = 0; i < 6; i++) begin
            wd[0] = 32'hA000_0000 + i; wd[1] = 32'hB000_0000 + i;
            sample();
            check("t2_wait", wt, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("t2_addr", mem_address, (i % 2 == 0) ? 15'h0100 : 15'h0200);
            check("t2_wdata", mem_writedata, (i % 2 == 0) ? 32'hA000_0000 + i : 32'hB000_0000 + i);
            drive_edge();
        end
        wr = 2'b00;

        // m1 read burst of 4 across the top of the address space.
        rd[1] = 1'b1; ad[1] = 15'h7FFE; bc[1] = 4'd4;
        for (int c = 0; c < 4 + RD_LAT; c++) begin
            sample();
            if (c == 0) check("t3_grant", wt[1], 1'b0);
            if (c < 4) check("t3_bus", {mem_chipselect, mem_write, mem_address}, {2'b10, 15'h7FFE + AW'(c)});
            else       check("t3_idle", mem_chipselect, 1'b0);
            check("t3_rdv1", rdv[1], (c >= RD_LAT) && (c < 4 + RD_LAT));
            check("t3_rdv0", rdv[0], 1'b0);
            if (rdv[1]) check("t3_rdata", rdat[1], init_val(15'h7FFE + AW'(c - RD_LAT)));
            drive_edge();
            rd[1] = 1'b0;
        end

        // m0 write burst of 3 with a 2-cycle stall after beat 1; m1 must wait.
        wr[0] = 1'b1; ad[0] = 15'h0300; bc[0] = 4'd3; wd[0] = 32'h1111_0000; be[0] = 4'hF;
        sample();
        check("t4_b1", {mem_chipselect, mem_write, mem_address, mem_writedata}, {2'b11, 15'h0300, 32'h1111_0000});
        drive_edge();
        wr[0] = 1'b0; rd[1] = 1'b1; ad[1] = 15'h0400; bc[1] = 4'd1;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("t4_stall_cs", mem_chipselect, 1'b0);
            check("t4_stall_wait", wt, 2'b10);
            drive_edge();
        end
        for (int c = 1; c < 3; c++) begin
            wr[0] = 1'b1; wd[0] = 32'h1111_0000 + c;
            sample();
            check("t4_beat", {mem_chipselect, mem_write, mem_address, mem_writedata},
                  {2'b11, 15'h0300 + AW'(c), 32'h1111_0000 + c});
            check("t4_m1_held", wt[1], 1'b1);
            drive_edge();
        end
        wr[0] = 1'b0;
        sample();
        check("t4_m1_grant", wt[1], 1'b0);
        check("t4_m1_bus", {mem_chipselect, mem_write, mem_address}, {2'b10, 15'h0400});
        drive_edge();
        rd[1] = 1'b0;

        // Reset on the second beat of a 4-beat read abandons the burst.
        rd[0] = 1'b1; ad[0] = 15'h0500; bc[0] = 4'd4;
        sample();
        check("t5_b1", mem_chipselect, 1'b1);
        drive_edge();
        rd[0] = 1'b0; reset = 1'b1;
        sample();
        check("t5_rst_cs", mem_chipselect, 1'b0);
        check("t5_rst_rdv", rdv, 2'b00);
        drive_edge();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            check("t5_after_cs", mem_chipselect, 1'b0);
            check("t5_after_rdv", rdv, 2'b00);
            drive_edge();
        end

        // burstcount 0 behaves as 1, 15 as MAX_BURST.
        run_read(1, 15'h0600, 4'd0, 1);
        run_read(0, 15'h0700, 4'd15, 8);

        // Random traffic against the transaction-level model.
        do_reset(1'b1);
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(AW'(i));
        for (int m = 0; m < 2; m++) begin act[m] = 1'b0; idx[m] = 0; nb[m] = 1; end
        last_win = 1;
        stop = 1'b0;
        drive_rand();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc == 4000) stop = 1'b1;
            sample();
            monitor();
            drive_edge();
            drive_rand();
            if (stop && !act[0] && !act[1] && acc_q.size() == 0 &&
                exp_rd[0].size() == 0 && exp_rd[1].size() == 0) break;
        end
        check("drain_acc", acc_q.size(), 0);
        check("drain_rd0", exp_rd[0].size(), 0);
        check("drain_rd1", exp_rd[1].size(), 0);
        check("drain_act", {act[1], act[0]}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
